axi_write_arbiter: RTL and testbench
====================================

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the AXI data width.
REQ-003 SHALL have port aclk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port m_awvalid  input  2  per-master write-address valid.
REQ-006 SHALL have port m_awaddr  input  2*ADDR_WIDTH  per-master address; master k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 SHALL have port m_awready  output  2  per-master write-address ready.
REQ-008 SHALL have port m_wvalid  input  2  per-master write-data valid.
REQ-009 SHALL have port m_wdata  input  2*DATA_WIDTH  per-master write data, packed as m_awaddr.
REQ-010 SHALL have port m_wready  output  2  per-master write-data ready.
REQ-011 SHALL have port m_bvalid  output  2  per-master write-response valid.
REQ-012 SHALL have port m_bready  input  2  per-master write-response ready.
REQ-013 SHALL have ports s_awvalid/s_awaddr/s_wvalid/s_wdata (outputs) and s_awready/s_wready (inputs), widths 1/ADDR_WIDTH/1/DATA_WIDTH/1/1, forming the shared slave AW and W channels.
REQ-014 SHALL have ports s_bvalid (input, 1) and s_bready (output, 1), forming the shared slave B channel.
REQ-015 SHALL have port grant  output  2  one-hot owner of the slave; 2'b00 when idle.

Function
REQ-016 SHALL implement FSM IDLE -> XFER -> RESP -> IDLE; exactly one write transaction in flight.
REQ-017 In IDLE, SHALL drive all s_*valid, s_bready, m_*ready and m_bvalid to 0.
REQ-018 In IDLE, if any m_awvalid bit is 1: register grant to the selected master and go to XFER; otherwise stay in IDLE with grant 2'b00.
REQ-019 SHALL have a one-cycle latency from m_awvalid high in IDLE to s_awvalid high.
REQ-020 In XFER, SHALL pass the AW channel (s_awvalid=m_awvalid[g], s_awaddr=granted addr, m_awready[g]=s_awready) until the AW handshake, then hold s_awvalid=0.
REQ-021 In XFER, SHALL pass the W channel the same way, independently of AW; AW and W may complete in either order or in the same cycle.
REQ-022 SHALL set sticky aw_done/w_done flags on the respective handshakes and go to RESP on the cycle both are set (including the same cycle).
REQ-023 In RESP, SHALL drive m_bvalid[g]=s_bvalid and s_bready=m_bready[g]; on the B handshake, clear grant, the done flags, and go to IDLE.
REQ-024 SHALL hold all ready/valid outputs of the non-granted master at 0 in every state.
REQ-025 SHALL pass address and data combinationally through muxes, with no added cycles in XFER or RESP.
REQ-026 SHALL ignore requests from the non-granted master until the next IDLE; its valids may stay asserted.

Reset
REQ-027 On areset high, including mid-transaction, SHALL immediately force state IDLE, grant 2'b00, done flags 0, all outputs 0, and the round-robin pointer to "master 0 preferred".
REQ-028 After areset deasserts, the first arbitration SHALL occur on the first rising edge of aclk with a request present.

Configuration
REQ-029 With macro AXI_ARB_ROUND_ROBIN_EN defined, SHALL arbitrate round-robin: on a tie the master not granted last wins; the pointer updates when the grant is taken.
REQ-030 Without AXI_ARB_ROUND_ROBIN_EN, SHALL use fixed priority (master 0 always wins a tie) and contain no pointer register.

Verification
REQ-031 Single master: m_awvalid=2'b01, addr 0x1000_0010, data 0xDEAD_BEEF; slave readies high -> s_awaddr=0x1000_0010 one cycle later, grant=01, m_bvalid[0] follows s_bvalid, grant=00 after the B handshake.
REQ-032 Tie, RR build: both masters requesting continuously over 4 transactions -> grant sequence 01,10,01,10; fixed build -> 01,01,01,01.
REQ-033 W before AW: s_wready=1 and s_awready=0 for 3 cycles -> W completes first, state stays XFER until the AW handshake, then RESP.
REQ-034 Backpressure: m_bready[g]=0 for 5 cycles with s_bvalid=1 -> s_bready=0 and grant held; the transaction completes on the cycle m_bready rises.
REQ-035 Reset mid-XFER: assert areset after the AW handshake, before W -> all outputs 0 within the same cycle, grant=00; a new request after reset is granted to master 0 (RR build).
REQ-036 Isolation: master 1 drives m_awvalid during master 0's transaction -> m_awready[1]=m_wready[1]=m_bvalid[1]=0 throughout.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// Two-master AXI write arbiter sharing one slave AW/W/B path.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin ties; fixed priority otherwise.
module axi_write_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [1:0]              m_awvalid,
  input  logic [2*ADDR_WIDTH-1:0] m_awaddr,
  output logic [1:0]              m_awready,
  input  logic [1:0]              m_wvalid,
  input  logic [2*DATA_WIDTH-1:0] m_wdata,
  output logic [1:0]              m_wready,
  output logic [1:0]              m_bvalid,
  input  logic [1:0]              m_bready,
  output logic                    s_awvalid,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awready,
  output logic                    s_wvalid,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic                    s_wready,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic sel;
  logic gi;
  logic aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] data_mux;

  assign gi    = grant_q[1];
  assign grant = grant_q;

  assign addr_mux = gi ? m_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                       : m_awaddr[ADDR_WIDTH-1:0];
  assign data_mux = gi ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                       : m_wdata[DATA_WIDTH-1:0];

`ifdef AXI_ARB_ROUND_ROBIN_EN
  // pref_q names the master that wins the next tie
  logic pref_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      pref_q <= 1'b0;
    else if (state_q == IDLE && |m_awvalid)
      pref_q <= ~sel;
  end

  assign sel = (&m_awvalid) ? pref_q : m_awvalid[1];
`else
  assign sel = m_awvalid[1] & ~m_awvalid[0];
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bvalid  = 2'b00;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_bready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|m_awvalid) begin
          grant_d = sel ? 2'b10 : 2'b01;
          state_d = XFER;
        end
      end
      XFER: begin
        s_awvalid     = ~aw_done_q & m_awvalid[gi];
        s_awaddr      = addr_mux;
        m_awready[gi] = ~aw_done_q & s_awready;
        s_wvalid      = ~w_done_q & m_wvalid[gi];
        s_wdata       = data_mux;
        m_wready[gi]  = ~w_done_q & s_wready;
        aw_hs         = s_awvalid & s_awready;
        w_hs          = s_wvalid & s_wready;
        aw_done_d     = aw_done_q | aw_hs;
        w_done_d      = w_done_q | w_hs;
        if (aw_done_d && w_done_d)
          state_d = RESP;
      end
      RESP: begin
        m_bvalid[gi] = s_bvalid;
        s_bready     = m_bready[gi];
        if (s_bvalid && m_bready[gi]) begin
          state_d   = IDLE;
          grant_d   = 2'b00;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: directed steps plus random transactions
// checked against a transaction-level arbitration model.
module tb_axi_write_arbiter;

  logic        aclk;
  logic        areset;
  logic [1:0]  m_awvalid;
  logic [63:0] m_awaddr;
  logic [1:0]  m_awready;
  logic [1:0]  m_wvalid;
  logic [63:0] m_wdata;
  logic [1:0]  m_wready;
  logic [1:0]  m_bvalid;
  logic [1:0]  m_bready;
  logic        s_awvalid;
  logic [31:0] s_awaddr;
  logic        s_awready;
  logic        s_wvalid;
  logic [31:0] s_wdata;
  logic        s_wready;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  grant;

  int n_cmp = 0;
  int n_err = 0;
  bit pref = 1'b0;
  logic [31:0] addr_m [2];
  logic [31:0] data_m [2];
  logic [1:0]  g;

  axi_write_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .m_awvalid(m_awvalid),
    .m_awaddr(m_awaddr),
    .m_awready(m_awready),
    .m_wvalid(m_wvalid),
    .m_wdata(m_wdata),
    .m_wready(m_wready),
    .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .s_awvalid(s_awvalid),
    .s_awaddr(s_awaddr),
    .s_awready(s_awready),
    .s_wvalid(s_wvalid),
    .s_wdata(s_wdata),
    .s_wready(s_wready),
    .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .grant(grant)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    m_awvalid = 2'b00;
    m_wvalid  = 2'b00;
    m_bready  = 2'b00;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    pref = 1'b0;
    step();
    step();
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_valid", {s_awvalid, s_wvalid, s_bready}, 0);
    chk("rst_m_out", {m_awready, m_wready, m_bvalid}, 0);
    areset = 1'b0;
  endtask

  // mode 0: all ready, 1: random, 2: W before AW, 3: B backpressure
  task automatic run_txn(input logic [1:0] req, input int mode,
                         input bit keep_ad, output logic [1:0] g_obs);
    int w;
    int cyc;
    bit aw_m, w_m, aw_s, w_s, bdone;
    logic [1:0] exp_g;
    if (req == 2'b11) w = int'(pref);
    else w = (req == 2'b10) ? 1 : 0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    pref = (w == 0);
`endif
    exp_g = (w == 1) ? 2'b10 : 2'b01;
    if (!keep_ad) begin
      for (int k = 0; k < 2; k++) begin
        addr_m[k] = $urandom;
        data_m[k] = $urandom;
      end
    end
    m_awaddr  = {addr_m[1], addr_m[0]};
    m_wdata   = {data_m[1], data_m[0]};
    m_awvalid = req;
    m_wvalid  = req;
    m_bready  = 2'b00;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    step();
    chk("grant", grant, exp_g);
    g_obs = grant;
    {aw_m, w_m, aw_s, w_s, bdone} = '0;
    cyc = 0;
    while (!bdone && cyc < 200) begin
      s_awready = (mode == 1) ? 1'($urandom_range(0, 1)) :
                  (mode == 2) ? (cyc >= 3) : 1'b1;
      s_wready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_bready  = (mode == 1) ? 2'($urandom_range(0, 3)) :
                  (mode == 3) ? ((cyc >= 6) ? 2'b11 : 2'b00) : 2'b11;
      s_bvalid  = aw_s && w_s;
      #1;
      chk("grant_hold", grant, exp_g);
      chk("isolation",
          {m_awready[1-w], m_wready[1-w], m_bvalid[1-w]}, 0);
      chk("s_awvalid", s_awvalid, !aw_s);
      chk("s_wvalid", s_wvalid, !w_s);
      if (s_awvalid) chk("s_awaddr", s_awaddr, addr_m[w]);
      if (s_wvalid) chk("s_wdata", s_wdata, data_m[w]);
      chk("aw_hs", m_awvalid[w] & m_awready[w], s_awvalid & s_awready);
      chk("w_hs", m_wvalid[w] & m_wready[w], s_wvalid & s_wready);
      if (aw_s && w_s) begin
        chk("m_bvalid", m_bvalid[w], 1'b1);
        chk("s_bready", s_bready, m_bready[w]);
      end else begin
        chk("s_bready_xfer", s_bready, 1'b0);
      end
      bdone = s_bvalid && s_bready;
      if (m_awvalid[w] && m_awready[w]) aw_m = 1'b1;
      if (m_wvalid[w] && m_wready[w]) w_m = 1'b1;
      if (s_awvalid && s_awready) aw_s = 1'b1;
      if (s_wvalid && s_wready) w_s = 1'b1;
      step();
      if (aw_m) m_awvalid[w] = 1'b0;
      if (w_m) m_wvalid[w] = 1'b0;
      cyc++;
    end
    chk("timeout", bdone, 1'b1);
    s_bvalid = 1'b0;
    m_bready = 2'b00;
    chk("grant_clr", grant, 2'b00);
    chk("idle_out", {m_bvalid, m_awready, m_wready, s_bready}, 0);
  endtask

  initial begin
    areset    = 1'b1;
    m_awaddr  = '0;
    m_wdata   = '0;
    clear_inputs();
    do_reset();

    // single master, fixed address/data
    addr_m[0] = 32'h1000_0010;
    data_m[0] = 32'hDEAD_BEEF;
    addr_m[1] = 32'h0;
    data_m[1] = 32'h0;
    run_txn(2'b01, 0, 1'b1, g);

    // tie from reset: RR alternates, fixed stays on master 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 0, 1'b0, g);
`ifdef AXI_ARB_ROUND_ROBIN_EN
      chk("tie_seq", g, (i % 2 == 1) ? 2'b10 : 2'b01);
`else
      chk("tie_seq", g, 2'b01);
`endif
    end

    run_txn(2'b01, 2, 1'b0, g);
    run_txn(2'b10, 3, 1'b0, g);
    run_txn(2'b11, 1, 1'b0, g);

    // reset after AW handshake, before W
    do_reset();
    m_awaddr  = {32'h0, 32'h2000_0000};
    m_awvalid = 2'b01;
    m_wvalid  = 2'b01;
    s_awready = 1'b1;
    s_wready  = 1'b0;
    step();
    chk("mid_grant", grant, 2'b01);
    step();
    chk("mid_aw_done", {s_awvalid, s_wvalid}, 2'b01);
    s_wready = 1'b1;
    areset   = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_s", {s_awvalid, s_wvalid, s_bready}, 0);
    chk("mid_rst_m", {m_awready, m_wready, m_bvalid}, 0);
    step();
    areset    = 1'b0;
    pref      = 1'b0;
    m_awvalid = 2'b11;
    m_wvalid  = 2'b11;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    step();
    chk("mid_rearb", grant, 2'b01);
    do_reset();

    for (int i = 0; i < 30; i++)
      run_txn(2'($urandom_range(1, 3)), 1, 1'b0, g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
